// File: rtl/mdio_responder.sv
// MDIO Clause 22 PHY-side responder.
// Decodes management frames arriving on mdc/mdio. Reads are served from an
// external 32 x 16-bit register port and writes are forwarded to it. The pad
// itself (tri-state buffer) is assembled outside from mdio_i/mdio_o/mdio_oe.
module mdio_responder #(
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  phy_addr,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    localparam int PCW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PCW-1:0] PRE_FULL = PCW'(PREAMBLE_LEN);
    localparam logic [PCW-1:0] PRE_ONE  = PCW'(1);
    localparam logic [PCW-1:0] PRE_ZERO = PCW'(0);

    typedef enum logic [3:0] {
        PREAMBLE = 4'd0,
        ST2      = 4'd1,
        OP       = 4'd2,
        PHYAD    = 4'd3,
        REGAD    = 4'd4,
        RD_TA    = 4'd5,
        RD_DATA  = 4'd6,
        RD_END   = 4'd7,
        WR_TA    = 4'd8,
        WR_DATA  = 4'd9,
        SKIP     = 4'd10
    } state_t;

    logic [SYNC_STAGES-1:0] mdc_sync_r;
    logic [SYNC_STAGES-1:0] mdio_sync_r;
    logic                   mdc_prev_r;
    logic                   rise_s;
    logic                   bit_s;

    state_t                 state_r;
    logic [PCW-1:0]         pre_cnt_r;
    logic [4:0]             bit_cnt_r;
    logic [15:0]            sh_r;
    logic                   op_first_r;
    logic                   op_rd_r;
    logic                   match_r;
    logic                   rd_pend_r;

    // Bring mdc and mdio into the clk domain through equal-depth chains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync_r  <= {SYNC_STAGES{1'b0}};
            mdio_sync_r <= {SYNC_STAGES{1'b0}};
            mdc_prev_r  <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[SYNC_STAGES-2:0], mdc};
            mdio_sync_r <= {mdio_sync_r[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_r  <= mdc_sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = mdc_sync_r[SYNC_STAGES-1] & ~mdc_prev_r;
    assign bit_s  = mdio_sync_r[SYNC_STAGES-1];

    // Frame decoder: every bit decision is taken on a synchronized mdc rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= PREAMBLE;
            pre_cnt_r  <= PRE_ZERO;
            bit_cnt_r  <= 5'd0;
            sh_r       <= 16'd0;
            op_first_r <= 1'b0;
            op_rd_r    <= 1'b0;
            match_r    <= 1'b0;
            rd_pend_r  <= 1'b0;
            mdio_o     <= 1'b0;
            mdio_oe    <= 1'b0;
            reg_addr   <= 5'd0;
            reg_rd     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_wdata  <= 16'd0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
            rd_pend_r <= reg_rd;
            if (rise_s) begin
                case (state_r)
                    PREAMBLE: begin
                        if (bit_s) begin
                            if (pre_cnt_r < PRE_FULL) begin
                                pre_cnt_r <= pre_cnt_r + PRE_ONE;
                            end
                        end else if (pre_cnt_r >= PRE_FULL) begin
                            state_r <= ST2;
                            busy    <= 1'b1;
                        end else begin
                            pre_cnt_r <= PRE_ZERO;
                        end
                    end
                    ST2: begin
                        if (bit_s) begin
                            state_r   <= OP;
                            bit_cnt_r <= 5'd0;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            pre_cnt_r <= PRE_ZERO;
                            state_r   <= PREAMBLE;
                        end
                    end
                    OP: begin
                        if (bit_cnt_r == 5'd0) begin
                            op_first_r <= bit_s;
                            bit_cnt_r  <= 5'd1;
                        end else if ({op_first_r, bit_s} == 2'b10 || {op_first_r, bit_s} == 2'b01) begin
                            op_rd_r   <= op_first_r;
                            state_r   <= PHYAD;
                            bit_cnt_r <= 5'd0;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            pre_cnt_r <= PRE_ZERO;
                            state_r   <= PREAMBLE;
                        end
                    end
                    PHYAD: begin
                        sh_r      <= {sh_r[14:0], bit_s};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd4) begin
                            match_r   <= ({sh_r[3:0], bit_s} == phy_addr);
                            state_r   <= REGAD;
                            bit_cnt_r <= 5'd0;
                        end
                    end
                    REGAD: begin
                        sh_r      <= {sh_r[14:0], bit_s};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd4) begin
                            reg_addr  <= {sh_r[3:0], bit_s};
                            bit_cnt_r <= 5'd0;
                            if (!match_r) begin
                                state_r <= SKIP;
                            end else if (op_rd_r) begin
                                reg_rd  <= 1'b1;
                                mdio_oe <= 1'b0;
                                state_r <= RD_TA;
                            end else begin
                                state_r <= WR_TA;
                            end
                        end
                    end
                    RD_TA: begin
                        // second turnaround bit: drive a 0 ahead of the data
                        mdio_oe   <= 1'b1;
                        mdio_o    <= 1'b0;
                        bit_cnt_r <= 5'd0;
                        state_r   <= RD_DATA;
                    end
                    RD_DATA: begin
                        mdio_o    <= sh_r[15];
                        sh_r      <= {sh_r[14:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd15) begin
                            state_r <= RD_END;
                        end
                    end
                    RD_END: begin
                        mdio_oe   <= 1'b0;
                        mdio_o    <= 1'b0;
                        busy      <= 1'b0;
                        pre_cnt_r <= PRE_ZERO;
                        state_r   <= PREAMBLE;
                    end
                    WR_TA: begin
                        if (bit_s == (bit_cnt_r == 5'd0)) begin
                            bit_cnt_r <= (bit_cnt_r == 5'd0) ? 5'd1 : 5'd0;
                            state_r   <= (bit_cnt_r == 5'd0) ? WR_TA : WR_DATA;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            pre_cnt_r <= PRE_ZERO;
                            state_r   <= PREAMBLE;
                        end
                    end
                    WR_DATA: begin
                        sh_r      <= {sh_r[14:0], bit_s};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd15) begin
                            reg_wdata <= {sh_r[14:0], bit_s};
                            reg_wr    <= 1'b1;
                            busy      <= 1'b0;
                            pre_cnt_r <= PRE_ZERO;
                            state_r   <= PREAMBLE;
                        end
                    end
                    SKIP: begin
                        // another PHY owns this frame: sit out turnaround and data
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd17) begin
                            busy      <= 1'b0;
                            pre_cnt_r <= PRE_ZERO;
                            state_r   <= PREAMBLE;
                        end
                    end
                    default: begin
                        mdio_oe   <= 1'b0;
                        busy      <= 1'b0;
                        pre_cnt_r <= PRE_ZERO;
                        state_r   <= PREAMBLE;
                    end
                endcase
            end
            // read data arrives the clk after the strobe; load it for shifting out
            if (rd_pend_r) begin
                sh_r <= reg_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder: a bus-level master drives frames,
// a register-port model answers reads, and two monitors compare strobes and
// returned read words against expectations queued by the stimulus.
module tb_mdio_responder;

    localparam int PRE = 32;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        m_drv = 1'b1;
    logic        m_en = 1'b1;
    logic        mdio_line;
    logic [4:0]  phy_addr = 5'd1;
    logic        mdio_o, mdio_oe, reg_rd, reg_wr, busy, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_rdata, reg_wdata;

    int          n_chk = 0;
    int          n_pass = 0;
    int          oe_clks = 0;
    int          rcnt = 0;
    logic [16:0] rsh = 17'd0;
    logic        mem_ready = 1'b0;
    logic [15:0] port_mem [32];
    logic [15:0] model [32];
    ev_t         ev_q [$];
    logic [15:0] rd_q [$];
    ev_t         mon_got, mon_exp;

    // line is pulled high when nobody drives it
    assign mdio_line = mdio_oe ? mdio_o : (m_en ? m_drv : 1'b1);

    mdio_responder #(.PREAMBLE_LEN(PRE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_line),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .phy_addr(phy_addr),
        .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .reg_wr(reg_wr), .reg_wdata(reg_wdata), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_init(input int i);
        if (i == 2) return 16'h1234;
        return 16'(i * 32'd40503 + 32'd12345);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // register port: stores writes, returns read data the clk after reg_rd
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) port_mem[i] <= mem_init(i);
            mem_ready <= 1'b1;
        end else if (reg_wr) begin
            port_mem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_rd ? port_mem[reg_addr] : 16'($urandom);
    end

    // count clks with the pad driven
    always @(posedge clk) if (mdio_oe) oe_clks <= oe_clks + 1;

    // strobe monitor
    always @(negedge clk) begin
        if (!rst && (reg_wr || reg_rd || frame_err)) begin
            mon_got.kind = reg_wr ? K_WR : (reg_rd ? K_RD : K_ERR);
            mon_got.addr = (reg_wr || reg_rd) ? reg_addr : 5'd0;
            mon_got.data = reg_wr ? reg_wdata : 16'd0;
            check("strobe_expected", 32'(ev_q.size() > 0), 32'd1);
            if (ev_q.size() > 0) begin
                mon_exp = ev_q.pop_front();
                check("strobe", {9'd0, mon_got}, {9'd0, mon_exp});
            end
        end
    end

    // read-word monitor: samples the line at each mdc rise while the slave drives
    always @(posedge mdc or posedge rst) begin
        if (rst) begin
            rcnt = 0;
        end else if (mdio_oe) begin
            rsh = {rsh[15:0], mdio_line};
            rcnt++;
            if (rcnt == 17) begin
                rcnt = 0;
                check("rd_word_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) check("rd_word", {15'd0, rsh}, {16'd0, rd_q.pop_front()});
            end
        end
    end

    task automatic mbit(input logic b, input logic drive);
        @(negedge clk);
        mdc = 1'b0; m_drv = b; m_en = drive;
        repeat (8) @(negedge clk);
        mdc = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] d);
        bit  acc, rd, wr, bad, hit;
        int  oe0;
        ev_t e;
        acc = (pre >= PRE);
        rd  = (op == 2'b10);
        wr  = (op == 2'b01);
        bad = acc && !rd && !wr;
        hit = acc && (pa == phy_addr);
        oe0 = oe_clks;
        if (bad) begin
            e.kind = K_ERR; e.addr = 5'd0; e.data = 16'd0; ev_q.push_back(e);
        end else if (hit && rd) begin
            e.kind = K_RD; e.addr = ra; e.data = 16'd0; ev_q.push_back(e);
            rd_q.push_back(model[ra]);
        end else if (hit && wr) begin
            e.kind = K_WR; e.addr = ra; e.data = d; ev_q.push_back(e);
            model[ra] = d;
        end
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1);
        mbit(1'b0, 1'b1);
        check("busy_at_start", 32'(busy), 32'(acc));
        mbit(1'b1, 1'b1);
        mbit(op[1], 1'b1);
        mbit(op[0], 1'b1);
        if (!bad) begin
            for (int i = 4; i >= 0; i--) mbit(pa[i], 1'b1);
            for (int i = 4; i >= 0; i--) mbit(ra[i], 1'b1);
            if (rd) begin
                if (hit) check("ta1_oe", 32'(mdio_oe), 32'd0);
                mbit(1'b1, 1'b0);
                if (hit) check("ta2_pad", {30'd0, mdio_oe, mdio_o}, 32'd2);
                for (int i = 0; i < 17; i++) begin
                    mbit(1'b1, 1'b0);
                    if (i == 15) check("busy_before_end", 32'(busy), 32'(acc));
                end
            end else begin
                mbit(1'b1, 1'b1);
                mbit(1'b0, 1'b1);
                for (int i = 15; i >= 0; i--) begin
                    mbit(d[i], 1'b1);
                    if (i == 1) check("busy_before_end", 32'(busy), 32'(acc));
                end
            end
        end
        repeat (4) @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        check("oe_end", 32'(mdio_oe), 32'd0);
        check("oe_activity", 32'(oe_clks != oe0), 32'(hit && rd));
        check("events_drained", 32'(ev_q.size() + rd_q.size()), 32'd0);
    endtask

    task automatic read_with_reset(input logic [4:0] ra);
        ev_t e;
        e.kind = K_RD; e.addr = ra; e.data = 16'd0; ev_q.push_back(e);
        for (int i = 0; i < PRE; i++) mbit(1'b1, 1'b1);
        mbit(1'b0, 1'b1); mbit(1'b1, 1'b1);
        mbit(1'b1, 1'b1); mbit(1'b0, 1'b1);
        for (int i = 4; i >= 0; i--) mbit(phy_addr[i], 1'b1);
        for (int i = 4; i >= 0; i--) mbit(ra[i], 1'b1);
        // TA1, TA2, then D15..D8 sampled: D7 is now on the line
        for (int i = 0; i < 10; i++) mbit(1'b1, 1'b0);
        check("oe_before_reset", 32'(mdio_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("oe_async_release", 32'(mdio_oe), 32'd0);
        check("reset_outputs_mid", {5'd0, mdio_o, mdio_oe, reg_rd, reg_wr, reg_addr,
                                    reg_wdata, busy, frame_err}, 32'd0);
        mdc = 1'b0; m_en = 1'b1; m_drv = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("events_drained_rst", 32'(ev_q.size() + rd_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = mem_init(i);
        repeat (3) @(negedge clk);
        check("reset_values", {5'd0, mdio_o, mdio_oe, reg_rd, reg_wr, reg_addr,
                               reg_wdata, busy, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        phy_addr = 5'd1;
        frame(PRE, 2'b01, 5'd1, 5'd4, 16'hA5C3);
        frame(PRE, 2'b10, 5'd1, 5'd2, 16'h0000);
        phy_addr = 5'd3;
        frame(PRE, 2'b10, 5'd1, 5'd2, 16'h0000);
        frame(PRE, 2'b10, 5'd3, 5'd4, 16'h0000);
        phy_addr = 5'd1;
        frame(PRE - 1, 2'b01, 5'd1, 5'd5, 16'h5A5A);
        frame(PRE, 2'b01, 5'd1, 5'd5, 16'h5A5A);
        frame(PRE, 2'b11, 5'd1, 5'd0, 16'h0000);
        frame(PRE, 2'b10, 5'd1, 5'd5, 16'h0000);
        read_with_reset(5'd4);
        frame(PRE, 2'b10, 5'd1, 5'd4, 16'h0000);

        for (int n = 0; n < 30; n++) begin
            int          kind;
            int          pre;
            logic [4:0]  pa;
            logic [4:0]  ra;
            logic [15:0] d;
            if ($urandom_range(0, 3) == 0) phy_addr = 5'($urandom);
            kind = $urandom_range(0, 9);
            pa   = ($urandom_range(0, 9) < 7) ? phy_addr : 5'($urandom);
            ra   = 5'($urandom);
            d    = 16'($urandom);
            pre  = PRE + $urandom_range(0, 2);
            case (kind)
                0:       frame(PRE - 1, 2'b01, pa, ra, d & 16'hFFFE);
                1:       frame(pre, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, pa, ra, d);
                2, 3, 4, 5: frame(pre, 2'b10, pa, ra, d);
                default: frame(pre, 2'b01, pa, ra, d);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
